// File: rtl/conv2d_stream.sv
// Valid-mode 2D convolution: buffers one image and one kernel per frame, then
// computes each output with one MAC per cycle and streams saturated results.
module conv2d_stream #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 24,
    parameter int OUT_W   = 16,
    parameter int MAX_DIM = 16,
    parameter int SIGNED  = 0,
    parameter int DIM_W   = $clog2(MAX_DIM + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DIM_W-1:0]  cfg_in_rows,
    input  logic [DIM_W-1:0]  cfg_in_cols,
    input  logic [DIM_W-1:0]  cfg_k_rows,
    input  logic [DIM_W-1:0]  cfg_k_cols,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              ker_valid,
    output logic              ker_ready,
    input  logic [DATA_W-1:0] ker_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_last,
    output logic              busy,
    output logic              cfg_err
);
    localparam int DEPTH = MAX_DIM * MAX_DIM;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = 2 * DIM_W;
    localparam logic [OUT_W-1:0] SMAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SMIN = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_LOAD_IMG, S_LOAD_KER, S_MAC, S_EMIT} state_t;
    state_t r_state, w_next;

    logic [DIM_W-1:0]  r_in_rows, r_in_cols, r_k_rows, r_k_cols;
    logic [DIM_W-1:0]  r_orow, r_ocol, r_kr, r_kc;
    logic [CW-1:0]     r_cnt;
    logic [ACC_W-1:0]  r_acc, r_prod;
    logic              r_prod_vld, r_issued_all, r_cfg_err;
    logic [DATA_W-1:0] r_img [DEPTH];
    logic [DATA_W-1:0] r_ker [DEPTH];

    logic              w_cfg_ok, w_img_last, w_ker_last, w_out_last, w_iss_last;
    logic [DIM_W-1:0]  w_nxt_orow, w_nxt_ocol;
    logic [DIM_W-1:0]  w_iss_orow, w_iss_ocol, w_iss_kr, w_iss_kc, w_adv_kr, w_adv_kc;
    logic [AW-1:0]     w_img_addr, w_ker_addr;
    logic [ACC_W-1:0]  w_prod;
    logic [OUT_W-1:0]  w_sat;

    function automatic logic [ACC_W-1:0] ext(input logic [DATA_W-1:0] v);
        if (SIGNED != 0) return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
        else             return {{(ACC_W-DATA_W){1'b0}}, v};
    endfunction

    always_comb begin
        w_cfg_ok = 1'b1;
        if (cfg_in_rows == '0 || cfg_in_cols == '0 || cfg_k_rows == '0 || cfg_k_cols == '0)
            w_cfg_ok = 1'b0;
        if (cfg_in_rows > DIM_W'(MAX_DIM) || cfg_in_cols > DIM_W'(MAX_DIM) ||
            cfg_k_rows > DIM_W'(MAX_DIM) || cfg_k_cols > DIM_W'(MAX_DIM))
            w_cfg_ok = 1'b0;
        if (cfg_k_rows > cfg_in_rows || cfg_k_cols > cfg_in_cols)
            w_cfg_ok = 1'b0;
    end

    assign w_img_last = (r_cnt == CW'(r_in_rows) * CW'(r_in_cols) - CW'(1));
    assign w_ker_last = (r_cnt == CW'(r_k_rows) * CW'(r_k_cols) - CW'(1));
    assign w_out_last = (r_orow == r_in_rows - r_k_rows) && (r_ocol == r_in_cols - r_k_cols);

    // During the output handshake the first product of the next window is
    // issued early, so the steady-state output spacing stays at K+1 cycles.
    always_comb begin
        w_nxt_orow = r_orow;
        w_nxt_ocol = r_ocol + DIM_W'(1);
        if (r_ocol == r_in_cols - r_k_cols) begin
            w_nxt_ocol = '0;
            w_nxt_orow = r_orow + DIM_W'(1);
        end
        if (r_state == S_EMIT) begin
            w_iss_orow = w_nxt_orow;
            w_iss_ocol = w_nxt_ocol;
            w_iss_kr   = '0;
            w_iss_kc   = '0;
        end else begin
            w_iss_orow = r_orow;
            w_iss_ocol = r_ocol;
            w_iss_kr   = r_kr;
            w_iss_kc   = r_kc;
        end
        w_adv_kr = w_iss_kr;
        w_adv_kc = w_iss_kc + DIM_W'(1);
        if (w_iss_kc == r_k_cols - DIM_W'(1)) begin
            w_adv_kc = '0;
            w_adv_kr = w_iss_kr + DIM_W'(1);
        end
        w_iss_last = (w_iss_kr == r_k_rows - DIM_W'(1)) && (w_iss_kc == r_k_cols - DIM_W'(1));
        w_img_addr = AW'(CW'(w_iss_orow + w_iss_kr) * CW'(r_in_cols) + CW'(w_iss_ocol + w_iss_kc));
        w_ker_addr = AW'(CW'(w_iss_kr) * CW'(r_k_cols) + CW'(w_iss_kc));
        w_prod     = ext(r_img[w_img_addr]) * ext(r_ker[w_ker_addr]);
    end

    always_comb begin
        w_sat = r_acc[OUT_W-1:0];
        if (SIGNED != 0) begin
            if (r_acc[ACC_W-1:OUT_W-1] != {(ACC_W-OUT_W+1){r_acc[ACC_W-1]}})
                w_sat = r_acc[ACC_W-1] ? SMIN : SMAX;
        end else if (|r_acc[ACC_W-1:OUT_W]) begin
            w_sat = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (cfg_valid && w_cfg_ok)      w_next = S_LOAD_IMG;
            S_LOAD_IMG: if (pix_valid && w_img_last)    w_next = S_LOAD_KER;
            S_LOAD_KER: if (ker_valid && w_ker_last)    w_next = S_MAC;
            S_MAC:      if (r_issued_all && r_prod_vld) w_next = S_EMIT;
            S_EMIT:     if (out_ready)                  w_next = w_out_last ? S_IDLE : S_MAC;
            default:                                    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = (r_state == S_IDLE);
        pix_ready = (r_state == S_LOAD_IMG);
        ker_ready = (r_state == S_LOAD_KER);
        out_valid = (r_state == S_EMIT);
        busy      = (r_state != S_IDLE);
        out_last  = (r_state == S_EMIT) && w_out_last;
        out_data  = (r_state == S_EMIT) ? w_sat : '0;
        cfg_err   = r_cfg_err;
    end

    always_ff @(posedge clk) begin
        if (r_state == S_LOAD_IMG && pix_valid) r_img[r_cnt[AW-1:0]] <= pix_data;
        if (r_state == S_LOAD_KER && ker_valid) r_ker[r_cnt[AW-1:0]] <= ker_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_rows    <= '0;
            r_in_cols    <= '0;
            r_k_rows     <= '0;
            r_k_cols     <= '0;
            r_orow       <= '0;
            r_ocol       <= '0;
            r_kr         <= '0;
            r_kc         <= '0;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_prod       <= '0;
            r_prod_vld   <= 1'b0;
            r_issued_all <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_cfg_err <= 1'b0;
            case (r_state)
                S_IDLE: if (cfg_valid) begin
                    r_in_rows <= cfg_in_rows;
                    r_in_cols <= cfg_in_cols;
                    r_k_rows  <= cfg_k_rows;
                    r_k_cols  <= cfg_k_cols;
                    r_cfg_err <= !w_cfg_ok;
                    r_cnt     <= '0;
                end
                S_LOAD_IMG: if (pix_valid) r_cnt <= w_img_last ? '0 : r_cnt + CW'(1);
                S_LOAD_KER: if (ker_valid) begin
                    if (w_ker_last) begin
                        r_cnt        <= '0;
                        r_orow       <= '0;
                        r_ocol       <= '0;
                        r_kr         <= '0;
                        r_kc         <= '0;
                        r_acc        <= '0;
                        r_prod_vld   <= 1'b0;
                        r_issued_all <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_MAC: begin
                    if (r_prod_vld) r_acc <= r_acc + r_prod;
                    if (!r_issued_all) begin
                        r_prod       <= w_prod;
                        r_prod_vld   <= 1'b1;
                        r_kr         <= w_adv_kr;
                        r_kc         <= w_adv_kc;
                        r_issued_all <= w_iss_last;
                    end else begin
                        r_prod_vld <= 1'b0;
                    end
                end
                S_EMIT: if (out_ready) begin
                    r_acc        <= '0;
                    r_orow       <= w_nxt_orow;
                    r_ocol       <= w_nxt_ocol;
                    r_prod       <= w_prod;
                    r_prod_vld   <= !w_out_last;
                    r_kr         <= w_adv_kr;
                    r_kc         <= w_adv_kc;
                    r_issued_all <= w_iss_last;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_conv2d_stream.sv
// Bench for conv2d_stream: unsigned and signed instances fed the same streams,
// each checked against a direct arithmetic convolution model.
module tb_conv2d_stream;
    localparam int DW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_valid;
    logic [DW-1:0] cfg_in_rows, cfg_in_cols, cfg_k_rows, cfg_k_cols;
    logic          pix_valid, ker_valid, out_ready;
    logic [7:0]    pix_data, ker_data;

    logic        cfg_ready_u, pix_ready_u, ker_ready_u, out_valid_u, out_last_u, busy_u, cfg_err_u;
    logic        cfg_ready_s, pix_ready_s, ker_ready_s, out_valid_s, out_last_s, busy_s, cfg_err_s;
    logic [15:0] out_data_u, out_data_s;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] img_q[$];
    logic [7:0] ker_q[$];
    longint     exp_u[$];
    longint     exp_s[$];
    int         g_ir, g_ic, g_kr, g_kc;

    conv2d_stream #(.DATA_W(8), .ACC_W(24), .OUT_W(16), .MAX_DIM(16), .SIGNED(0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_u),
        .cfg_in_rows(cfg_in_rows), .cfg_in_cols(cfg_in_cols),
        .cfg_k_rows(cfg_k_rows), .cfg_k_cols(cfg_k_cols),
        .pix_valid(pix_valid), .pix_ready(pix_ready_u), .pix_data(pix_data),
        .ker_valid(ker_valid), .ker_ready(ker_ready_u), .ker_data(ker_data),
        .out_valid(out_valid_u), .out_ready(out_ready), .out_data(out_data_u),
        .out_last(out_last_u), .busy(busy_u), .cfg_err(cfg_err_u)
    );

    conv2d_stream #(.DATA_W(8), .ACC_W(24), .OUT_W(16), .MAX_DIM(16), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_s),
        .cfg_in_rows(cfg_in_rows), .cfg_in_cols(cfg_in_cols),
        .cfg_k_rows(cfg_k_rows), .cfg_k_cols(cfg_k_cols),
        .pix_valid(pix_valid), .pix_ready(pix_ready_s), .pix_data(pix_data),
        .ker_valid(ker_valid), .ker_ready(ker_ready_s), .ker_data(ker_data),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .out_last(out_last_s), .busy(busy_s), .cfg_err(cfg_err_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint clamp(input longint v, input int sgn);
        if (sgn != 0) return (v > 32767) ? 32767 : ((v < -32768) ? -32768 : v);
        return (v > 65535) ? 65535 : ((v < 0) ? 0 : v);
    endfunction

    function automatic longint conv_at(input int r, input int c, input int sgn);
        longint sum = 0;
        longint a, b;
        for (int i = 0; i < g_kr; i++) begin
            for (int j = 0; j < g_kc; j++) begin
                a = (sgn != 0) ? longint'($signed(img_q[(r+i)*g_ic + c+j])) : longint'(img_q[(r+i)*g_ic + c+j]);
                b = (sgn != 0) ? longint'($signed(ker_q[i*g_kc + j])) : longint'(ker_q[i*g_kc + j]);
                sum += a * b;
            end
        end
        return clamp(sum, sgn);
    endfunction

    task automatic build_model(input int ir, input int ic, input int kr, input int kc);
        g_ir = ir; g_ic = ic; g_kr = kr; g_kc = kc;
        exp_u.delete();
        exp_s.delete();
        for (int r = 0; r <= ir - kr; r++)
            for (int c = 0; c <= ic - kc; c++) begin
                exp_u.push_back(conv_at(r, c, 0));
                exp_s.push_back(conv_at(r, c, 1));
            end
    endtask

    task automatic send_cfg(input int ir, input int ic, input int kr, input int kc);
        int t = 0;
        @(negedge clk);
        while (!cfg_ready_u && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("cfg_ready_wait", cfg_ready_u, 1);
        cfg_valid   = 1'b1;
        cfg_in_rows = DW'(ir);
        cfg_in_cols = DW'(ic);
        cfg_k_rows  = DW'(kr);
        cfg_k_cols  = DW'(kc);
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // Streams image then kernel; the idle stream is driven with junk to show it is ignored.
    task automatic stream_in();
        int  idx = 0;
        int  t = 0;
        bit  hs;
        while (idx < g_ir * g_ic && t < 4000) begin
            pix_valid = ($urandom_range(0, 3) != 0);
            pix_data  = img_q[idx];
            ker_valid = 1'b1;
            ker_data  = 8'($urandom);
            chk("ker_ready_in_img", ker_ready_u, 0);
            hs = pix_valid && pix_ready_u;
            @(posedge clk);
            if (hs) idx++;
            t++;
            @(negedge clk);
        end
        chk("pix_count", idx, g_ir * g_ic);
        idx = 0;
        t = 0;
        while (idx < g_kr * g_kc && t < 4000) begin
            ker_valid = ($urandom_range(0, 3) != 0);
            ker_data  = ker_q[idx];
            pix_valid = 1'b1;
            pix_data  = 8'($urandom);
            chk("pix_ready_in_ker", pix_ready_u, 0);
            hs = ker_valid && ker_ready_u;
            @(posedge clk);
            if (hs) idx++;
            t++;
            @(negedge clk);
        end
        chk("ker_count", idx, g_kr * g_kc);
        pix_valid = 1'b0;
        ker_valid = 1'b0;
    endtask

    // rmode 0: ready always high, 1: stall first beat 5 cycles, 2: random ready.
    task automatic collect(input int rmode);
        int  n = exp_u.size();
        int  k = 0;
        int  edges = 0;
        int  t = 0;
        int  hold = 0;
        int  prev_rise = 0;
        bit  seen = 1'b0;
        bit  hs;
        int  kk = g_kr * g_kc;
        while (k < n && t < 20000) begin
            hs = 1'b0;
            if (out_valid_u) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (k == 0) chk("first_latency", edges, kk + 1);
                    else if (rmode == 0) chk("beat_gap", edges - prev_rise, kk + 1);
                    prev_rise = edges;
                end
                chk("out_data", out_data_u, exp_u[k]);
                chk("out_last", out_last_u, (k == n - 1) ? 1 : 0);
                chk("out_valid_s", out_valid_s, 1);
                chk("out_data_s", longint'($signed(out_data_s)), exp_s[k]);
                chk("out_last_s", out_last_s, (k == n - 1) ? 1 : 0);
                if (rmode == 0) out_ready = 1'b1;
                else if (rmode == 1) begin
                    if (k == 0 && hold < 5) begin
                        out_ready = 1'b0;
                        hold++;
                    end else out_ready = 1'b1;
                end else out_ready = 1'($urandom_range(0, 1));
                hs = out_ready;
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            edges++;
            t++;
            if (hs) begin
                k++;
                seen = 1'b0;
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("beat_count", k, n);
        chk("cfg_ready_after", cfg_ready_u, 1);
        chk("cfg_ready_after_s", cfg_ready_s, 1);
        chk("busy_after", busy_u, 0);
        chk("busy_after_s", busy_s, 0);
        @(negedge clk);
        chk("no_extra_beat", out_valid_u, 0);
    endtask

    task automatic run_frame(input int ir, input int ic, input int kr, input int kc, input int rmode);
        build_model(ir, ic, kr, kc);
        send_cfg(ir, ic, kr, kc);
        chk("busy_after_cfg", busy_u, 1);
        stream_in();
        collect(rmode);
    endtask

    task automatic cfg_bad(input int ir, input int ic, input int kr, input int kc);
        send_cfg(ir, ic, kr, kc);
        chk("cfg_err_pulse", cfg_err_u, 1);
        chk("cfg_err_pulse_s", cfg_err_s, 1);
        chk("cfg_err_busy", busy_u, 0);
        chk("cfg_err_pix_ready", pix_ready_u, 0);
        chk("cfg_err_pix_ready_s", pix_ready_s, 0);
        chk("cfg_err_ker_ready_s", ker_ready_s, 0);
        chk("cfg_err_stay_idle", cfg_ready_u, 1);
        @(negedge clk);
        chk("cfg_err_one_cycle", cfg_err_u, 0);
        chk("cfg_err_pix_ready2", pix_ready_u, 0);
    endtask

    task automatic load_basic();
        img_q.delete();
        ker_q.delete();
        for (int i = 1; i <= 9; i++) img_q.push_back(8'(i));
        for (int i = 0; i < 4; i++) ker_q.push_back(8'd1);
    endtask

    initial begin
        int t;
        rst_n = 1'b0;
        cfg_valid = 1'b0;
        cfg_in_rows = '0; cfg_in_cols = '0; cfg_k_rows = '0; cfg_k_cols = '0;
        pix_valid = 1'b0; pix_data = '0;
        ker_valid = 1'b0; ker_data = '0;
        out_ready = 1'b0;
        #12;
        chk("rst_cfg_ready", cfg_ready_u, 1);
        chk("rst_busy", busy_u, 0);
        chk("rst_out_valid", out_valid_u, 0);
        chk("rst_out_data", out_data_u, 0);
        chk("rst_cfg_err", cfg_err_u, 0);
        chk("rst_pix_ready", pix_ready_u, 0);
        @(negedge clk);
        rst_n = 1'b1;

        load_basic();
        run_frame(3, 3, 2, 2, 0);
        run_frame(3, 3, 2, 2, 1);

        img_q.delete();
        ker_q.delete();
        for (int i = 0; i < 256; i++) begin
            img_q.push_back(8'hFF);
            ker_q.push_back(8'hFF);
        end
        run_frame(16, 16, 16, 16, 2);

        img_q = '{8'h80, 8'h80};
        ker_q = '{8'h80, 8'h80};
        run_frame(1, 2, 1, 2, 0);
        ker_q = '{8'h80, 8'h7F};
        run_frame(1, 2, 1, 2, 0);

        cfg_bad(3, 3, 4, 2);
        cfg_bad(3, 3, 2, 0);
        cfg_bad(17, 3, 1, 1);
        cfg_bad(3, 3, 2, 4);
        cfg_bad(0, 3, 1, 1);

        // Reset during MAC, then during an output stall.
        load_basic();
        build_model(3, 3, 2, 2);
        send_cfg(3, 3, 2, 2);
        stream_in();
        @(posedge clk);
        #2;
        chk("busy_in_mac", busy_u, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mac_busy", busy_u, 0);
        chk("rst_mac_out_valid", out_valid_u, 0);
        chk("rst_mac_cfg_ready", cfg_ready_u, 1);
        @(negedge clk);
        rst_n = 1'b1;

        send_cfg(3, 3, 2, 2);
        stream_in();
        t = 0;
        while (!out_valid_u && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("reach_emit", out_valid_u, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_emit_out_valid", out_valid_u, 0);
        chk("rst_emit_out_data", out_data_u, 0);
        chk("rst_emit_busy", busy_u, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(3, 3, 2, 2, 0);

        for (int f = 0; f < 8; f++) begin
            int ir, ic, kr, kc;
            ir = $urandom_range(1, 6);
            ic = $urandom_range(1, 6);
            kr = $urandom_range(1, ir);
            kc = $urandom_range(1, ic);
            img_q.delete();
            ker_q.delete();
            for (int i = 0; i < ir * ic; i++) img_q.push_back(8'($urandom));
            for (int i = 0; i < kr * kc; i++) ker_q.push_back(8'($urandom));
            run_frame(ir, ic, kr, kc, 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/conv2d_stream.md
Name: conv2d_stream

Overview:
Parametrised 2D valid-mode convolution engine with per-frame runtime dimensions. It takes a configuration beat, then an image stream, then a kernel stream, and computes every output with one MAC per cycle. Results stream out row-major under valid/ready backpressure. Sits between the pixel source and downstream post-processing. It adds handshakes, a signed mode, output saturation and configuration checking.

Parameters:
DATA_W, 8, width of image and kernel elements
ACC_W, 24, accumulator width; must be at least 2*DATA_W + clog2(MAX_DIM*MAX_DIM)
OUT_W, 16, output width; saturated from the accumulator
MAX_DIM, 16, maximum rows/cols for image and kernel; buffers are MAX_DIM*MAX_DIM entries each
SIGNED, 0, 0 = unsigned arithmetic, 1 = two's-complement arithmetic
DIM_W, clog2(MAX_DIM+1), width of dimension fields (derived)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  configuration beat valid
cfg_ready  out  1  high only in IDLE
cfg_in_rows  in  DIM_W  image rows, actual count (1..MAX_DIM)
cfg_in_cols  in  DIM_W  image cols
cfg_k_rows  in  DIM_W  kernel rows
cfg_k_cols  in  DIM_W  kernel cols
pix_valid  in  1  image element valid
pix_ready  out  1  high only in LOAD_IMG
pix_data  in  DATA_W  image element, row-major
ker_valid  in  1  kernel element valid
ker_ready  out  1  high only in LOAD_KER
ker_data  in  DATA_W  kernel element, row-major
out_valid  out  1  output element valid
out_ready  in  1  downstream accept
out_data  out  OUT_W  saturated convolution result
out_last  out  1  qualifies the final output of the frame
busy  out  1  high in any state other than IDLE
cfg_err  out  1  one-cycle pulse on a rejected configuration

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE; all counters and the accumulator clear; all outputs are 0 except cfg_ready, which is 1 once in IDLE. Buffer contents are don't-care.
- Handshake: a transfer occurs on a rising edge with valid&&ready. out_valid, once high, holds with out_data and out_last stable until accepted.
- IDLE: on a cfg handshake, all four dimensions are latched.
  - The config is invalid if any dimension is 0, any dimension exceeds MAX_DIM, k_rows > in_rows, or k_cols > in_cols.
  - Invalid config: pulse cfg_err for 1 cycle and stay in IDLE.
  - Valid config: go to LOAD_IMG.
- LOAD_IMG: accept in_rows*in_cols elements into the image buffer at address r*in_cols+c. After the last one, go to LOAD_KER.
- LOAD_KER: accept k_rows*k_cols elements. After the last one, go to MAC with output indices (orow, ocol) = (0, 0).
- MAC: one product per cycle, img[orow+kr][ocol+kc]*ker[kr][kc], kc fastest. Takes k_rows*k_cols cycles, then go to EMIT.
  - Products and accumulation are sign-extended if SIGNED=1, zero-extended otherwise.
  - The accumulator cannot overflow, given the ACC_W constraint.
- EMIT: out_valid=1. out_data is the accumulator clamped to the OUT_W range:
  - unsigned: [0, 2^OUT_W-1]
  - signed: [-2^(OUT_W-1), 2^(OUT_W-1)-1]
- out_last=1 when orow = in_rows-k_rows and ocol = in_cols-k_cols.
- On the out handshake: clear the accumulator and advance ocol, wrapping to 0 and incrementing orow.
  - After the last output, go to IDLE; cfg_ready is high the next cycle.
  - Otherwise, go back to MAC.
- Latency: the first out_valid rises exactly k_rows*k_cols+1 cycles after the final kernel handshake edge. With out_ready tied high, consecutive outputs are k_rows*k_cols+1 cycles apart.
- Output count per frame is (in_rows-k_rows+1)*(in_cols-k_cols+1). A 1x1 output frame asserts out_last on its only beat.
- Inputs presented in the wrong phase are ignored: their ready is low and nothing is consumed.
- Reset asserted mid-frame discards the frame. The next frame needs a new cfg beat.

Test Plan:
- Basic: unsigned cfg 3x3 image / 2x2 kernel, image 1..9, kernel all 1 -> outputs 12, 16, 24, 28 in order; out_last only on 28; cfg_ready returns high after.
- Backpressure: same frame, out_ready low for 5 cycles while out_valid is high -> out_data=12 held stable; no loss or duplication; 4 beats total.
- Saturation: unsigned 16x16 image and 16x16 kernel, all 255, OUT_W=16 -> sum 16646400 -> single output 65535 with out_last=1.
- Signed: SIGNED=1, cfg 1x2 image [-128, -128], 1x2 kernel [-128, -128] -> sum 32768 -> out_data 32767. A second frame with kernel [-128, 127] -> 128.
- Config error: cfg k_rows=4 with in_rows=3, then k_cols=0 -> cfg_err pulses for 1 cycle each; busy stays 0; pix_ready stays 0.
- Reset mid-operation: assert rst_n low during MAC of the basic frame -> out_valid and busy go 0 immediately. A new basic frame afterwards gives 12, 16, 24, 28.
